// File: rtl/vsmp_pkg.sv
// rtl/vsmp_pkg.sv - shared types and defaults for the VSMP program loader
package vsmp_pkg;

  localparam int VSMP_NUM_WORDS = 4;
  localparam int VSMP_WORD_W    = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HI
  } loader_state_t;

endpackage

// File: rtl/vsmp_sync2.sv
// rtl/vsmp_sync2.sv - two-flop synchronizer with configurable reset value
module vsmp_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/vsmp_program_loader.sv
// rtl/vsmp_program_loader.sv - serial program loader with atomic commit to the memory word bus
module vsmp_program_loader
  import vsmp_pkg::*;
#(
  parameter int NUM_WORDS  = VSMP_NUM_WORDS,
  parameter int WORD_W     = VSMP_WORD_W,
  parameter int BIT_CYCLES = 4,
  localparam int IDX_W     = $clog2(NUM_WORDS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        input1,
  input  logic                        load_req,
  output logic [NUM_WORDS*WORD_W-1:0] meme,
  output logic                        prog_valid,
  output logic                        load_done,
  output logic                        frame_err,
  output logic [IDX_W-1:0]            word_idx,
  output logic                        busy
);

  localparam int TMR_W = $clog2(BIT_CYCLES);
  localparam int CNT_W = $clog2(WORD_W);
  localparam logic [TMR_W-1:0] TMR_MID  = TMR_W'(BIT_CYCLES / 2 - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WORDS - 1);

  loader_state_t state_q, state_d;
  logic          rx;
  logic [TMR_W-1:0] bit_tmr;
  logic [CNT_W-1:0] bit_cnt;
  logic [WORD_W-1:0] shift_reg;
  logic [(NUM_WORDS-1)*WORD_W-1:0] shadow;

  logic tmr_clr, tmr_run, shift_en, store_en, commit_en, err_en;

  vsmp_sync2 #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (input1),
    .q     (rx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    tmr_clr   = 1'b0;
    tmr_run   = 1'b0;
    shift_en  = 1'b0;
    store_en  = 1'b0;
    commit_en = 1'b0;
    err_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx) begin
          state_d = START;
          tmr_clr = 1'b1;
        end
      end
      START: begin
        if (bit_tmr == TMR_MID) begin
          tmr_clr = 1'b1;
          state_d = rx ? IDLE : DATA;
        end else begin
          tmr_run = 1'b1;
        end
      end
      DATA: begin
        if (bit_tmr == TMR_LAST) begin
          tmr_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_cnt == CNT_LAST) state_d = STOP;
        end else begin
          tmr_run = 1'b1;
        end
      end
      STOP: begin
        if (bit_tmr == TMR_LAST) begin
          tmr_clr = 1'b1;
          if (rx) begin
            state_d = IDLE;
            if (word_idx == IDX_LAST) commit_en = 1'b1;
            else                      store_en  = 1'b1;
          end else begin
            err_en  = 1'b1;
            state_d = WAIT_HI;
          end
        end else begin
          tmr_run = 1'b1;
        end
      end
      WAIT_HI: begin
        if (rx) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A reload request wins over anything the frame logic decided this cycle.
    if (load_req) begin
      state_d   = WAIT_HI;
      tmr_clr   = 1'b1;
      tmr_run   = 1'b0;
      shift_en  = 1'b0;
      store_en  = 1'b0;
      commit_en = 1'b0;
      err_en    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_tmr    <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      shadow     <= '0;
      meme       <= '0;
      word_idx   <= '0;
      prog_valid <= 1'b0;
      load_done  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      load_done <= commit_en;
      frame_err <= err_en;

      if (tmr_clr)      bit_tmr <= '0;
      else if (tmr_run) bit_tmr <= bit_tmr + 1'b1;

      if (load_req || state_q != DATA) bit_cnt <= '0;
      else if (shift_en)               bit_cnt <= bit_cnt + 1'b1;

      if (shift_en) shift_reg <= {rx, shift_reg[WORD_W-1:1]};

      if (store_en) begin
        for (int i = 0; i < NUM_WORDS - 1; i++) begin
          if (word_idx == IDX_W'(i)) shadow[i*WORD_W +: WORD_W] <= shift_reg;
        end
      end

      if (commit_en) meme <= {shift_reg, shadow};

      if (load_req || err_en || commit_en) word_idx <= '0;
      else if (store_en)                   word_idx <= word_idx + 1'b1;

      if (load_req)       prog_valid <= 1'b0;
      else if (commit_en) prog_valid <= 1'b1;
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_vsmp_program_loader.sv
// tb/tb_vsmp_program_loader.sv - scoreboard bench for the VSMP program loader
module tb_vsmp_program_loader;

  localparam int NW = 4;
  localparam int WW = 8;
  localparam int BC = 4;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b1;
  logic          input1   = 1'b1;
  logic          load_req = 1'b0;
  logic [NW*WW-1:0] meme;
  logic          prog_valid;
  logic          load_done;
  logic          frame_err;
  logic [1:0]    word_idx;
  logic          busy;

  int checks   = 0;
  int errors   = 0;
  int err_cnt  = 0;
  int done_cnt = 0;
  int err_base;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  vsmp_program_loader #(
    .NUM_WORDS  (NW),
    .WORD_W     (WW),
    .BIT_CYCLES (BC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .input1     (input1),
    .load_req   (load_req),
    .meme       (meme),
    .prog_valid (prog_valid),
    .load_done  (load_done),
    .frame_err  (frame_err),
    .word_idx   (word_idx),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    input1 = b;
    tick(BC);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop = 1'b1, input logic req_at_stop = 1'b0);
    send_bit(1'b0);
    for (int i = 0; i < WW; i++) send_bit(d[i]);
    send_bit(stop);
    input1 = 1'b1;
    if (req_at_stop) begin
      load_req = 1'b1;
      tick(1);
      load_req = 1'b0;
      tick(BC - 1);
    end else begin
      tick(BC);
    end
  endtask

  task automatic send_prog(input logic [31:0] w, input logic req_last = 1'b0);
    if (!req_last) sb_q.push_back(w);
    for (int i = 0; i < NW; i++) send_byte(w[i*WW +: WW], 1'b1, req_last && (i == NW - 1));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (load_done) begin
        done_cnt++;
        check("sb_depth_at_done", 32'(sb_q.size()), 1);
        if (sb_q.size() != 0) begin
          check("meme_commit", meme, sb_q.pop_front());
          check("pv_at_commit", prog_valid, 1);
        end
      end
      if (frame_err) err_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    #2 rst_n = 1'b0;
    tick(3);
    check("rst_meme", meme, 0);
    check("rst_pv", prog_valid, 0);
    check("rst_done", load_done, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_idx", word_idx, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick(4);

    // basic load
    send_prog(32'h78563412);
    tick(4);
    check("t1_meme", meme, 32'h78563412);
    check("t1_pv", prog_valid, 1);
    check("t1_idx", word_idx, 0);
    check("t1_err", err_cnt, 0);
    check("t1_done", done_cnt, 1);

    // glitch while idle with one word already buffered
    send_byte(8'h99);
    check("t2_idx_pre", word_idx, 1);
    input1 = 1'b0;
    tick(2);
    input1 = 1'b1;
    tick(12);
    check("t2_busy", busy, 0);
    check("t2_idx", word_idx, 1);
    check("t2_err", err_cnt, 0);

    // bad stop bit restarts the program
    send_byte(8'hAA);
    send_byte(8'h55);
    check("t3_idx_pre", word_idx, 3);
    send_byte(8'h3C, 1'b0);
    tick(4);
    check("t3_err", err_cnt, 1);
    check("t3_idx", word_idx, 0);
    check("t3_meme_kept", meme, 32'h78563412);
    check("t3_pv_kept", prog_valid, 1);
    send_prog(32'h04030201);
    tick(4);
    check("t3_meme", meme, 32'h04030201);
    check("t3_done", done_cnt, 2);

    // load_req on the final stop-bit sample
    send_prog(32'h78563412);
    tick(4);
    check("t4_done_pre", done_cnt, 3);
    send_prog(32'h44332211, 1'b1);
    tick(4);
    check("t4_pv", prog_valid, 0);
    check("t4_meme", meme, 32'h78563412);
    check("t4_done", done_cnt, 3);
    check("t4_idx", word_idx, 0);
    check("t4_err", err_cnt, 1);

    // async reset in the middle of word 2
    send_byte(8'h11);
    send_byte(8'h22);
    input1 = 1'b0;
    tick(BC);
    send_bit(1'b1);
    send_bit(1'b0);
    input1 = 1'b1;
    tick(1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_meme", meme, 0);
    check("t5_pv", prog_valid, 0);
    check("t5_done", load_done, 0);
    check("t5_ferr", frame_err, 0);
    check("t5_idx", word_idx, 0);
    check("t5_busy", busy, 0);
    tick(3);
    rst_n = 1'b1;
    tick(4);
    send_prog(32'hDEADBEEF);
    tick(4);
    check("t5_reload", meme, 32'hDEADBEEF);
    check("t5_reload_pv", prog_valid, 1);
    check("t5_reload_done", done_cnt, 4);

    // stuck-low line
    err_base = err_cnt;
    input1 = 1'b0;
    tick(44);
    check("t6_busy_low", busy, 1);
    check("t6_err_low", err_cnt - err_base, 1);
    input1 = 1'b1;
    tick(8);
    check("t6_busy_hi", busy, 0);
    check("t6_err_hi", err_cnt - err_base, 1);
    check("t6_idx", word_idx, 0);
    check("t6_meme_kept", meme, 32'hDEADBEEF);

    check("sb_empty", 32'(sb_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
